// File: rtl/alu_control_issue_if.sv
// rtl/alu_control_issue_if.sv - ALUControl issue bundle: upstream op handshake, downstream decoded-op handshake, optional illegal counter (ILLEGAL_CNT_EN)
interface alu_control_issue_if
`ifdef ILLEGAL_CNT_EN
    #(parameter int CNT_W = 8)
`endif
    ();

    // upstream (control unit -> issue FIFO)
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    // downstream (issue FIFO -> execute stage)
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_control;
    logic        br_ne;
    logic        illegal;

`ifdef ILLEGAL_CNT_EN
    logic [CNT_W-1:0] illegal_cnt;
    logic             cnt_clr;
`endif

    // control unit / execute stage side
    modport master (
        output in_valid, alu_op, opcode, funct, out_ready,
`ifdef ILLEGAL_CNT_EN
        output cnt_clr,
        input  illegal_cnt,
`endif
        input  in_ready, out_valid, alu_control, br_ne, illegal
    );

    // issue block side
    modport slave (
        input  in_valid, alu_op, opcode, funct, out_ready,
`ifdef ILLEGAL_CNT_EN
        input  cnt_clr,
        output illegal_cnt,
`endif
        output in_ready, out_valid, alu_control, br_ne, illegal
    );

endinterface

// File: rtl/alu_control_issue.sv
// rtl/alu_control_issue.sv - ALU control decode plus valid/ready issue FIFO; optional saturating illegal-op counter under ILLEGAL_CNT_EN
module alu_control_issue #(
    parameter int DEPTH = 2
`ifdef ILLEGAL_CNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_control_issue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    // entry layout: {alu_control[3:0], br_ne, illegal}
    logic [5:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic [3:0] dec_code;
    logic       dec_br_ne;
    logic       dec_illegal;
    logic       full, empty, push, pop;
    logic [5:0] head;

    // decode the incoming op; anything unlisted falls through to the illegal encoding
    always_comb begin
        dec_code    = 4'b1111;
        dec_br_ne   = 1'b0;
        dec_illegal = 1'b1;
        case (bus.alu_op)
            2'b00: begin
                dec_code    = 4'b0010;
                dec_illegal = 1'b0;
            end
            2'b01: begin
                case (bus.opcode)
                    6'h04: begin
                        dec_code    = 4'b0110;
                        dec_illegal = 1'b0;
                    end
                    6'h05: begin
                        dec_code    = 4'b0110;
                        dec_br_ne   = 1'b1;
                        dec_illegal = 1'b0;
                    end
                    default: ;
                endcase
            end
            2'b10: begin
                case (bus.funct)
                    6'h20: begin dec_code = 4'b0010; dec_illegal = 1'b0; end
                    6'h22: begin dec_code = 4'b0110; dec_illegal = 1'b0; end
                    6'h24: begin dec_code = 4'b0000; dec_illegal = 1'b0; end
                    6'h25: begin dec_code = 4'b0001; dec_illegal = 1'b0; end
                    6'h2A: begin dec_code = 4'b0111; dec_illegal = 1'b0; end
                    default: ;
                endcase
            end
            default: begin
                case (bus.opcode)
                    6'h08: begin dec_code = 4'b0010; dec_illegal = 1'b0; end
                    6'h0C: begin dec_code = 4'b0000; dec_illegal = 1'b0; end
                    6'h0D: begin dec_code = 4'b0001; dec_illegal = 1'b0; end
                    6'h0A: begin dec_code = 4'b0111; dec_illegal = 1'b0; end
                    default: ;
                endcase
            end
        endcase
    end

    // in_ready depends only on registered occupancy, never on out_ready
    assign full  = (occ_q == FULL_OCC);
    assign empty = (occ_q == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = bus.out_ready & ~empty;

    // pointer and occupancy next state
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (push) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // pointer/occupancy registers; reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    // storage is not reset: outputs are masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {dec_code, dec_br_ne, dec_illegal};
        end
    end

    assign head            = mem_q[rd_q];
    assign bus.in_ready    = ~full;
    assign bus.out_valid   = ~empty;
    assign bus.alu_control = empty ? 4'b0000 : head[5:2];
    assign bus.br_ne       = empty ? 1'b0 : head[1];
    assign bus.illegal     = empty ? 1'b0 : head[0];

`ifdef ILLEGAL_CNT_EN
    logic [CNT_W-1:0] icnt_q, icnt_d;

    // clear wins over a simultaneous illegal push; increment stops at all-ones
    always_comb begin
        icnt_d = icnt_q;
        if (bus.cnt_clr) begin
            icnt_d = '0;
        end else if (push && dec_illegal && (icnt_q != '1)) begin
            icnt_d = icnt_q + CNT_W'(1);
        end
    end

    // illegal-op counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt_q <= '0;
        end else begin
            icnt_q <= icnt_d;
        end
    end

    assign bus.illegal_cnt = icnt_q;
`endif

endmodule

// File: tb/tb_alu_control_issue.sv
// tb/tb_alu_control_issue.sv - randomized and directed self-checking bench for alu_control_issue
module tb_alu_control_issue;

    localparam int DEPTH = 2;
`ifdef ILLEGAL_CNT_EN
    localparam int CNT_W = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

`ifdef ILLEGAL_CNT_EN
    alu_control_issue_if #(.CNT_W(CNT_W)) bus ();
    alu_control_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`else
    alu_control_issue_if bus ();
    alu_control_issue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // reference model: queue of expected {code, br_ne, illegal} entries
    logic [5:0] model_q[$];
    int         model_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ref_decode(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn);
        logic [5:0] bad;
        bad = {4'b1111, 1'b0, 1'b1};
        if (op == 2'd0) return {4'd2, 1'b0, 1'b0};
        if (op == 2'd1) begin
            if (opc == 6'd4) return {4'd6, 1'b0, 1'b0};
            if (opc == 6'd5) return {4'd6, 1'b1, 1'b0};
            return bad;
        end
        if (op == 2'd2) begin
            if (fn == 6'd32) return {4'd2, 2'b00};
            if (fn == 6'd34) return {4'd6, 2'b00};
            if (fn == 6'd36) return {4'd0, 2'b00};
            if (fn == 6'd37) return {4'd1, 2'b00};
            if (fn == 6'd42) return {4'd7, 2'b00};
            return bad;
        end
        if (opc == 6'd8)  return {4'd2, 2'b00};
        if (opc == 6'd12) return {4'd0, 2'b00};
        if (opc == 6'd13) return {4'd1, 2'b00};
        if (opc == 6'd10) return {4'd7, 2'b00};
        return bad;
    endfunction

    task automatic check_outputs(input string tag);
        logic [5:0] e;
        logic       v;
        v = (model_q.size() != 0);
        e = v ? model_q[0] : 6'h00;
        check({tag, ".out_valid"},   bus.out_valid,   v);
        check({tag, ".in_ready"},    bus.in_ready,    model_q.size() < DEPTH);
        check({tag, ".alu_control"}, bus.alu_control, e[5:2]);
        check({tag, ".br_ne"},       bus.br_ne,       e[1]);
        check({tag, ".illegal"},     bus.illegal,     e[0]);
`ifdef ILLEGAL_CNT_EN
        check({tag, ".illegal_cnt"}, bus.illegal_cnt, model_cnt);
`endif
    endtask

    // one clock: check outputs, apply inputs at the falling edge, advance the model at the rising edge
    task automatic step(input string tag, input logic iv, input logic [1:0] op, input logic [5:0] opc,
                        input logic [5:0] fn, input logic ordy, input logic clr);
        logic       do_push, do_pop;
        logic [5:0] e;
        @(negedge clk);
        check_outputs(tag);
        bus.in_valid  = iv;
        bus.alu_op    = op;
        bus.opcode    = opc;
        bus.funct     = fn;
        bus.out_ready = ordy;
`ifdef ILLEGAL_CNT_EN
        bus.cnt_clr   = clr;
`endif
        e       = ref_decode(op, opc, fn);
        do_push = iv && (model_q.size() < DEPTH);
        do_pop  = ordy && (model_q.size() != 0);
        @(posedge clk);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(e);
        if (clr) model_cnt = 0;
        else if (do_push && e[0] && model_cnt < 3) model_cnt++;
    endtask

    task automatic reset_now(input string tag);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        model_q.delete();
        model_cnt = 0;
        check_outputs({tag, ".low"});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs({tag, ".rel"});
    endtask

    function automatic logic [5:0] pick_opcode();
        case ($urandom_range(0, 8))
            0: return 6'h04;
            1: return 6'h05;
            2: return 6'h08;
            3: return 6'h0C;
            4: return 6'h0D;
            5: return 6'h0A;
            6: return 6'h06;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] pick_funct();
        case ($urandom_range(0, 6))
            0: return 6'h20;
            1: return 6'h22;
            2: return 6'h24;
            3: return 6'h25;
            4: return 6'h2A;
            5: return 6'h3F;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        logic [5:0] fset [5];
        fset = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_op    = 2'b00;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.out_ready = 1'b0;
`ifdef ILLEGAL_CNT_EN
        bus.cnt_clr   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        reset_now("init");

        // R-type decode sweep with the execute stage always ready
        foreach (fset[i]) step("rtype", 1'b1, 2'b10, 6'h00, fset[i], 1'b1, 1'b0);
        step("rtype_drain", 1'b0, 2'b00, 6'h00, 6'h00, 1'b1, 1'b0);

        // branch sense and illegal branch opcode
        step("br_eq",  1'b1, 2'b01, 6'h04, 6'h00, 1'b1, 1'b0);
        step("br_ne",  1'b1, 2'b01, 6'h05, 6'h00, 1'b1, 1'b0);
        step("br_bad", 1'b1, 2'b01, 6'h06, 6'h00, 1'b1, 1'b0);
        step("br_drain", 1'b0, 2'b00, 6'h00, 6'h00, 1'b1, 1'b0);

        // backpressure: third op must be held upstream, then order preserved on release
        step("bp_push0", 1'b1, 2'b11, 6'h08, 6'h00, 1'b0, 1'b0);
        step("bp_push1", 1'b1, 2'b11, 6'h0C, 6'h00, 1'b0, 1'b0);
        step("bp_push2", 1'b1, 2'b11, 6'h0D, 6'h00, 1'b0, 1'b0);
        step("bp_hold",  1'b1, 2'b11, 6'h0D, 6'h00, 1'b0, 1'b0);
        repeat (3) step("bp_release", 1'b0, 2'b00, 6'h00, 6'h00, 1'b1, 1'b0);

        // full with simultaneous valid/ready pops only; then push+pop at occupancy 1 with wrap
        step("full0", 1'b1, 2'b00, 6'h00, 6'h00, 1'b0, 1'b0);
        step("full1", 1'b1, 2'b11, 6'h0A, 6'h00, 1'b0, 1'b0);
        step("full_pp", 1'b1, 2'b10, 6'h00, 6'h25, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            step("half_pp", 1'b1, 2'b10, 6'h00, fset[i % 5], 1'b1, 1'b0);
        step("half_drain", 1'b0, 2'b00, 6'h00, 6'h00, 1'b1, 1'b0);

        // reset with two entries queued
        step("pre_rst0", 1'b1, 2'b01, 6'h05, 6'h00, 1'b0, 1'b0);
        step("pre_rst1", 1'b1, 2'b10, 6'h00, 6'h3F, 1'b0, 1'b0);
        step("pre_rst2", 1'b0, 2'b00, 6'h00, 6'h00, 1'b0, 1'b0);
        reset_now("mid_rst");

`ifdef ILLEGAL_CNT_EN
        // counter saturation and clear priority
        for (int i = 0; i < 5; i++) step("cnt_sat", 1'b1, 2'b10, 6'h00, 6'h3F, 1'b1, 1'b0);
        step("cnt_clr", 1'b1, 2'b10, 6'h00, 6'h3F, 1'b1, 1'b1);
        step("cnt_after", 1'b0, 2'b00, 6'h00, 6'h00, 1'b1, 1'b0);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom), pick_opcode(), pick_funct(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        check_outputs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
